// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (subtractor now, adder later).
// No logic: state encodings and legal operand-width bounds only.
// No flow control.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell computing a - b - bin, mirror of the full-adder cell.
// Purely combinational, zero latency.
// No flow control.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor diff = a - b, LSB first; signed ovf output when SERIAL_SUBTRACTOR_OVF_EN is defined.
// Latency: start accepted at edge N, busy for WIDTH cycles, done pulse in cycle N+WIDTH+1.
// start/busy/done handshake: start is only sampled in IDLE; ignored while busy or done.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
            $error("serial_subtractor: WIDTH outside supported range");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;
    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic [WIDTH-1:0] w_res_nxt;

    full_subtractor u_fs (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .bin  (r_borrow),
        .diff (w_d),
        .bout (w_bout)
    );

    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic r_a_msb;
    logic r_b_msb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            ovf     <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end else if (r_state == ST_RUN && w_last) begin
            ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
        end
    end
`endif

    // Outputs load on the edge entering DONE so they are already valid while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa       <= '0;
            r_sb       <= '0;
            r_res      <= '0;
            r_borrow   <= 1'b0;
            r_cnt      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sa     <= a;
                        r_sb     <= b;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    r_sa     <= {1'b0, r_sa[WIDTH-1:1]};
                    r_sb     <= {1'b0, r_sb[WIDTH-1:1]};
                    r_res    <= w_res_nxt;
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        diff       <= w_res_nxt;
                        borrow_out <= w_bout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8); ovf is checked when SERIAL_SUBTRACTOR_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    exp_t sb[$];
    exp_t hold;
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   dones    = 0;
    int   pushed   = 0;

    // Directed vectors: a, b, expected diff, borrow, signed overflow.
    logic [W-1:0] tv_a  [7] = '{8'h03, 8'h00, 8'hFF, 8'h00, 8'h80, 8'h7F, 8'h05};
    logic [W-1:0] tv_b  [7] = '{8'h05, 8'h00, 8'h01, 8'h01, 8'h01, 8'hFF, 8'h03};
    logic [W-1:0] tv_d  [7] = '{8'hFE, 8'h00, 8'hFE, 8'hFF, 8'h7F, 8'h80, 8'h02};
    logic         tv_bo [7] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
    logic         tv_ov [7] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out", name);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!busy && !done) return;
            @(negedge clk);
        end
        fail_timeout("wait_idle");
    endtask

    task automatic push_exp(input logic [W-1:0] ed, input logic eb, input logic eo);
        exp_t e;
        e.d  = ed;
        e.bo = eb;
        e.ov = eo;
        sb.push_back(e);
        pushed++;
    endtask

    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] ed, input logic eb, input logic eo,
                         input bit push);
        wait_idle();
        a     = av;
        b     = bv;
        start = 1'b1;
        if (push) push_exp(ed, eb, eo);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_diff"}, diff, 0);
        chk({tag, "_borrow"}, borrow_out, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk({tag, "_ovf"}, ovf, 0);
`endif
    endtask

    int busy_cnt;
    int done_at;
    int d0;
    int k;

    initial begin
        hold = '0;
        fork
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    hold = '0;
                end else begin
                    chk("busy_and_done", {31'd0, busy & done}, 0);
                    if (done) begin
                        dones++;
                        if (sb.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_done diff=0x%0h", diff);
                        end else begin
                            mon_e = sb.pop_front();
                            chk("res_diff", diff, mon_e.d);
                            chk("res_borrow", borrow_out, mon_e.bo);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                            chk("res_ovf", ovf, mon_e.ov);
`endif
                            hold = mon_e;
                        end
                    end else begin
                        chk("hold_diff", diff, hold.d);
                        chk("hold_borrow", borrow_out, hold.bo);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        chk("hold_ovf", ovf, hold.ov);
`endif
                    end
                end
            end
            begin
                #200000;
                $display("FAIL watchdog expired");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Latency: 5 - 3, busy for 8 cycles, done in the 9th
        wait_idle();
        a = 8'h05; b = 8'h03; start = 1'b1;
        push_exp(8'h02, 1'b0, 1'b0);
        busy_cnt = 0;
        done_at  = 0;
        for (int i = 1; i <= 20 && done_at == 0; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) done_at = i;
        end
        chk("lat_busy_cycles", busy_cnt, 8);
        chk("lat_done_cycle", done_at, 9);

        for (int i = 0; i < 7; i++)
            do_op(tv_a[i], tv_b[i], tv_d[i], tv_bo[i], tv_ov[i], 1'b1);

        // start and operand noise during RUN is ignored
        do_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b1);
        d0 = dones;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = (i == 2 || i == 3);
            if (i == 2) begin
                a = 8'hAA; b = 8'h55;
            end else begin
                a = W'($urandom); b = W'($urandom);
            end
        end
        start = 1'b0;
        chk("noise_one_done", dones - d0, 1);

        // Back-to-back: restart in the cycle after done
        do_op(8'h20, 8'h30, 8'hF0, 1'b1, 1'b0, 1'b1);
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!done) fail_timeout("b2b_first_done");
        @(negedge clk);
        a = 8'h01; b = 8'h02; start = 1'b1;
        push_exp(8'hFF, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_accept", busy, 1);

        // Reset during the 4th RUN cycle aborts with no done pulse
        do_op(8'h80, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("abort_pre_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        #2 rst_n = 1'b1;
        d0 = dones;
        repeat (12) @(negedge clk);
        chk("abort_no_done", dones - d0, 0);

        do_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b1);

        k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("sb_drained", sb.size(), 0);
        chk("done_count", dones, pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial unsigned subtractor, the inverse operation of the team's full-adder datapath. It computes DIFF = A - B, LSB first, one bit per clock through a single one-bit full-subtractor cell and a borrow flip-flop. It uses a start/busy/done handshake, so an arithmetic sequencer can reuse one small cell for wide operands.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), bit-count register width (derived; do not override).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start cycle.
- b  input  WIDTH  subtrahend; captured on the accepted start cycle.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  result a-b mod 2^WIDTH; held until the next completion.
- borrow_out  output  1  final borrow; 1 iff a < b unsigned; held with diff.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - busy=0, done=0, diff=0, borrow_out=0.
  - Internal shift registers, borrow FF and bit counter all cleared.
- State machine, IDLE -> RUN -> DONE -> IDLE:
  - IDLE, start=1: capture a into sa and b into sb; borrow FF=0; count=0; next state RUN.
  - IDLE, start=0: remain in IDLE.
  - RUN, each cycle: the cell takes ai=sa[0], bi=sb[0], bin=borrow FF.
    - d = ai^bi^bin.
    - bout = (~ai & bi) | (~(ai^bi) & bin).
    - The result shift register shifts right with d entering at the MSB.
    - sa and sb shift right; borrow FF=bout; count++.
  - RUN, when count==WIDTH-1 on the current cycle: next state DONE.
  - DONE: diff <= result register (including the bit produced in the last RUN cycle); borrow_out <= final borrow; done=1 for exactly this cycle; next state IDLE.
- busy=1 exactly while in RUN. busy and done are never high together.
- Latency: start accepted at edge N -> busy high for cycles N+1..N+WIDTH -> done high in cycle N+WIDTH+1.
  - A new start is accepted in the cycle after done (throughput of one op per WIDTH+2 cycles).
- start while RUN or DONE: ignored. Operands are not recaptured and the in-flight operation is unaffected.
- a and b may change freely after the capture cycle without effect.
- diff and borrow_out change only in DONE. Between operations they keep the last result.
- Reset asserted mid-operation: immediate abort to IDLE with all outputs at reset values. No done pulse is produced for the aborted operation.
- Wrap-around: diff is modulo 2^WIDTH. For example, 0 - 1 gives all ones with borrow_out=1.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - Adds output port `ovf  output  1`, the signed (two's-complement) overflow flag.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), computed from the captured operand MSBs.
  - ovf updates in DONE together with diff, resets to 0, and holds between operations.
- Undefined: no ovf port and no extra flops. All other behaviour is identical.

Decomposition:
- Shared package/include serial_arith_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - WIDTH range-check constants.
  - These are reused by a future serial_adder.
- One natural sub-module, full_subtractor: purely combinational, ports (a, b, bin, diff, bout). It is the mirror of the existing full-adder cell and is instantiated once.
- The FSM, shift registers and counter live in the top module.

Test Plan:
1. WIDTH=8, start with a=0x05, b=0x03 -> busy high for 8 cycles; done in cycle 9 after start; diff=0x02, borrow_out=0.
2. a=0x03, b=0x05 -> diff=0xFE, borrow_out=1. Then a=0x00, b=0x00 -> diff=0x00, borrow_out=0. Then a=0xFF, b=0x01 -> diff=0xFE, borrow_out=0.
3. Start a=0x10, b=0x01; pulse start with a=0xAA, b=0x55 during RUN; change a/b every cycle -> ignored; result diff=0x0F, exactly one done pulse.
4. Back-to-back: assert start in the cycle after done -> accepted; second result correct; the first result is held until the second done.
5. Assert rst_n low at the 4th RUN cycle of a=0x80, b=0x01 -> busy=0, done=0, diff=0, borrow_out=0 immediately; no done pulse follows release.
6. With SERIAL_SUBTRACTOR_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, ovf=1; a=0x7F, b=0xFF -> diff=0x80, ovf=1, borrow_out=1; a=0x05, b=0x03 -> ovf=0.
